// File: rtl/duc_hop_ctrl_if.sv
// Bundle of the hop-scheduler control, table-write and DDS/mixer signals.
// master: link-layer sequencer side; slave: duc_hop_ctrl.
interface duc_hop_ctrl_if;
  logic        tbl_wr_en;
  logic [5:0]  tbl_wr_addr;
  logic [27:0] tbl_wr_data;
  logic        tx_start;
  logic        tx_stop;
  logic        hop_valid;
  logic [5:0]  hop_chan;
  logic        hop_ready;
  logic [27:0] fcw_data;
  logic        tx_dds_en;
  logic        tx_data_en;
  logic        hop_strobe;
  logic        busy;
  logic        underrun;
  logic [15:0] hop_cnt;

  modport master (
    output tbl_wr_en, tbl_wr_addr, tbl_wr_data, tx_start, tx_stop,
           hop_valid, hop_chan,
    input  hop_ready, fcw_data, tx_dds_en, tx_data_en, hop_strobe,
           busy, underrun, hop_cnt
  );

  modport slave (
    input  tbl_wr_en, tbl_wr_addr, tbl_wr_data, tx_start, tx_stop,
           hop_valid, hop_chan,
    output hop_ready, fcw_data, tx_dds_en, tx_data_en, hop_strobe,
           busy, underrun, hop_cnt
  );
endinterface

// File: rtl/duc_hop_ctrl.sv
// Frequency-hop scheduler for the TX DUC: 64-entry FCW table, hop-index
// queue, fixed slot grid, single-cycle DDS load and post-load TX blanking.
module duc_hop_ctrl #(
  parameter int HOP_PERIOD = 1300,
  parameter int GUARD      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk_200m,
  input  logic           cfg_rst,
  duc_hop_ctrl_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_slot_cnt;
  logic          r_stop_pend;

  logic [27:0]   r_tbl [64];
  logic [27:0]   r_fcw;

  logic [5:0]    r_q [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_q_cnt;

  logic          r_loaded;
  logic          r_dds_en;
  logic          r_data_en;
  logic          r_underrun;
  logic [15:0]   r_hop_cnt;

  logic          w_full;
  logic          w_empty;
  logic          w_hop_ready;
  logic          w_push;
  logic          w_pop;
  logic          w_slot_start;
  logic          w_slot_last;
  logic          w_start;
  logic          w_busy;
  logic          w_strobe;
  logic [5:0]    w_head;

  assign w_full       = (r_q_cnt == CW'(FIFO_DEPTH));
  assign w_empty      = (r_q_cnt == '0);
  // Held low while in reset so the sequencer sees no room until release.
  assign w_hop_ready  = !w_full && !cfg_rst;
  assign w_push       = bus.hop_valid && w_hop_ready;
  assign w_slot_start = (r_state == RUN) && (r_slot_cnt == 16'd0);
  assign w_slot_last  = (r_state == RUN) && (r_slot_cnt == 16'(HOP_PERIOD - 1));
  assign w_pop        = w_slot_start && !w_empty;
  assign w_head       = r_q[r_rd_ptr];

  // FSM state register
  always_ff @(posedge clk_200m or posedge cfg_rst) begin
    if (cfg_rst) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state and decoded outputs; a stop request is honoured only on the slot's last cycle
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_strobe    = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.tx_start) begin
          w_state_nxt = RUN;
          w_start     = 1'b1;
        end
      end
      RUN: begin
        w_busy   = 1'b1;
        w_strobe = (r_slot_cnt == 16'd0);
        if (w_slot_last && (r_stop_pend || bus.tx_stop)) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Slot position counter and latched stop request
  always_ff @(posedge clk_200m or posedge cfg_rst) begin
    if (cfg_rst) begin
      r_slot_cnt  <= '0;
      r_stop_pend <= 1'b0;
    end else if (r_state == RUN) begin
      r_slot_cnt <= w_slot_last ? 16'd0 : r_slot_cnt + 16'd1;
      if (w_state_nxt == IDLE)  r_stop_pend <= 1'b0;
      else if (bus.tx_stop)     r_stop_pend <= 1'b1;
    end else begin
      r_slot_cnt  <= '0;
      r_stop_pend <= 1'b0;
    end
  end

  // Hop queue pointers and occupancy; reset flushes by clearing these only
  always_ff @(posedge clk_200m or posedge cfg_rst) begin
    if (cfg_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_q_cnt  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_q_cnt <= r_q_cnt + CW'(1);
        2'b01:   r_q_cnt <= r_q_cnt - CW'(1);
        default: r_q_cnt <= r_q_cnt;
      endcase
    end
  end

  // Hop queue storage
  always_ff @(posedge clk_200m) begin
    if (w_push) r_q[r_wr_ptr] <= bus.hop_chan;
  end

  // FCW table write port; contents survive reset
  always_ff @(posedge clk_200m) begin
    if (bus.tbl_wr_en) r_tbl[bus.tbl_wr_addr] <= bus.tbl_wr_data;
  end

  // Registered table read on pop; old contents win on a same-address write, and the value is held until the next load
  always_ff @(posedge clk_200m or posedge cfg_rst) begin
    if (cfg_rst)    r_fcw <= '0;
    else if (w_pop) r_fcw <= r_tbl[w_head];
  end

  // Per-slot status: load strobe, loaded flag, underrun, hop counter, data gate
  always_ff @(posedge clk_200m or posedge cfg_rst) begin
    if (cfg_rst) begin
      r_loaded   <= 1'b0;
      r_dds_en   <= 1'b0;
      r_data_en  <= 1'b0;
      r_underrun <= 1'b0;
      r_hop_cnt  <= '0;
    end else begin
      r_dds_en  <= w_pop;
      r_data_en <= (r_state == RUN) && r_loaded &&
                   (r_slot_cnt >= 16'(GUARD + 1)) &&
                   (r_slot_cnt <= 16'(HOP_PERIOD - 2));
      if (w_start) begin
        r_underrun <= 1'b0;
        r_hop_cnt  <= '0;
        r_loaded   <= 1'b0;
      end else if (w_slot_start) begin
        r_hop_cnt <= r_hop_cnt + 16'd1;
        r_loaded  <= !w_empty;
        if (w_empty) r_underrun <= 1'b1;
      end
    end
  end

  assign bus.hop_ready  = w_hop_ready;
  assign bus.fcw_data   = r_fcw;
  assign bus.tx_dds_en  = r_dds_en;
  assign bus.tx_data_en = r_data_en;
  assign bus.hop_strobe = w_strobe;
  assign bus.busy       = w_busy;
  assign bus.underrun   = r_underrun;
  assign bus.hop_cnt    = r_hop_cnt;

endmodule

// File: tb/tb_duc_hop_ctrl.sv
// Scoreboard bench for duc_hop_ctrl: expected FCWs queued at hop accept,
// compared whenever the DDS load strobe fires.
module tb_duc_hop_ctrl;
  localparam int HP = 1300;
  localparam int G  = 12;
  localparam int FD = 4;

  logic clk_200m = 1'b0;
  logic cfg_rst  = 1'b1;
  always #5 clk_200m = ~clk_200m;

  duc_hop_ctrl_if hif();

  duc_hop_ctrl #(.HOP_PERIOD(HP), .GUARD(G), .FIFO_DEPTH(FD)) dut (
    .clk_200m (clk_200m),
    .cfg_rst  (cfg_rst),
    .bus      (hif)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          exp_hc = 0;
  logic [27:0] tbl_m [64];
  logic [27:0] sb [$];
  logic [27:0] exp_fcw;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=0x%0h exp=0x%0h", tag, act, exp);
    end
  endtask

  // Every DDS load must match the oldest outstanding expectation
  always @(negedge clk_200m) begin
    if (!cfg_rst && hif.tx_dds_en) begin
      if (sb.size() == 0) chk("dds_unexpected", 1, 0);
      else begin
        exp_fcw = sb.pop_front();
        chk("fcw", hif.fcw_data, exp_fcw);
      end
    end
  end

  task automatic wr_tbl(input logic [5:0] a, input logic [27:0] d);
    hif.tbl_wr_en = 1'b1; hif.tbl_wr_addr = a; hif.tbl_wr_data = d;
    @(negedge clk_200m);
    hif.tbl_wr_en = 1'b0;
    tbl_m[a] = d;
  endtask

  task automatic push_hop(input logic [5:0] ch, input int max_wait);
    bit done = 1'b0;
    hif.hop_valid = 1'b1; hif.hop_chan = ch;
    for (int n = 0; n < max_wait && !done; n++) begin
      if (hif.hop_ready) begin
        sb.push_back(tbl_m[ch]);
        done = 1'b1;
      end
      @(negedge clk_200m);
    end
    hif.hop_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic pulse_start(input bit with_stop);
    hif.tx_start = 1'b1; hif.tx_stop = with_stop;
    @(negedge clk_200m);
    hif.tx_start = 1'b0; hif.tx_stop = 1'b0;
    exp_hc = 0;
    chk("start_strobe", hif.hop_strobe, 1);
    chk("start_busy", hif.busy, 1);
  endtask

  // Called at the negedge where hop_strobe is high; returns at the next slot's first cycle
  task automatic run_slot(input bit loaded, input bit exp_und, input int stop_pos,
                          input bit wr, input logic [5:0] wa, input logic [27:0] wd);
    exp_hc++;
    if (wr) begin
      hif.tbl_wr_en = 1'b1; hif.tbl_wr_addr = wa; hif.tbl_wr_data = wd;
    end
    for (int pos = 1; pos < HP; pos++) begin
      @(negedge clk_200m);
      hif.tx_stop = 1'b0;
      if (pos == 1) begin
        if (wr) begin
          hif.tbl_wr_en = 1'b0;
          tbl_m[wa] = wd;
        end
        chk("dds_en", hif.tx_dds_en, loaded);
        chk("hop_cnt", hif.hop_cnt, exp_hc);
        chk("underrun", hif.underrun, exp_und);
      end
      if (pos == 2)     chk("dds_pulse", hif.tx_dds_en, 0);
      if (pos == G + 1) chk("guard_end", hif.tx_data_en, 0);
      if (pos == G + 2) chk("data_rise", hif.tx_data_en, loaded);
      if (pos == HP - 1) begin
        chk("data_last", hif.tx_data_en, loaded);
        chk("busy_last", hif.busy, 1);
      end
      if (pos == stop_pos) hif.tx_stop = 1'b1;
    end
    @(negedge clk_200m);
    hif.tx_stop = 1'b0;
    if (stop_pos >= 0) begin
      chk("stop_busy", hif.busy, 0);
      chk("stop_data", hif.tx_data_en, 0);
      chk("stop_strobe", hif.hop_strobe, 0);
    end else begin
      chk("strobe_next", hif.hop_strobe, 1);
    end
  endtask

  initial begin
    hif.tbl_wr_en = 1'b0; hif.tbl_wr_addr = '0; hif.tbl_wr_data = '0;
    hif.tx_start = 1'b0; hif.tx_stop = 1'b0;
    hif.hop_valid = 1'b0; hif.hop_chan = '0;

    // Reset state
    repeat (2) @(negedge clk_200m);
    chk("rst_ready", hif.hop_ready, 0);
    chk("rst_busy", hif.busy, 0);
    chk("rst_fcw", hif.fcw_data, 0);
    chk("rst_hopcnt", hif.hop_cnt, 0);
    cfg_rst = 1'b0;
    @(negedge clk_200m);
    chk("rel_ready", hif.hop_ready, 1);
    chk("rel_strobe", hif.hop_strobe, 0);

    wr_tbl(6'd1, 28'h0A0A0A1);
    wr_tbl(6'd2, 28'h0B0B0B2);
    wr_tbl(6'd3, 28'h0C0C0C3);
    wr_tbl(6'd4, 28'h0D0D0D4);
    wr_tbl(6'd5, 28'h1234567);
    wr_tbl(6'd7, 28'h7777777);

    // Single loaded slot; stop lands on the slot's last cycle
    push_hop(6'd5, 10);
    pulse_start(1'b0);
    run_slot(1'b1, 1'b0, HP - 1, 1'b0, 6'd0, 28'd0);

    // Fill the queue, fifth entry waits for the first pop
    push_hop(6'd1, 10);
    push_hop(6'd2, 10);
    push_hop(6'd3, 10);
    push_hop(6'd4, 10);
    chk("full_ready", hif.hop_ready, 0);
    fork
      push_hop(6'd5, 2 * HP);
      begin
        pulse_start(1'b0);
        run_slot(1'b1, 1'b0, -1, 1'b0, 6'd0, 28'd0);
        run_slot(1'b1, 1'b0, -1, 1'b0, 6'd0, 28'd0);
        run_slot(1'b1, 1'b0, -1, 1'b0, 6'd0, 28'd0);
        run_slot(1'b1, 1'b0, -1, 1'b0, 6'd0, 28'd0);
        run_slot(1'b1, 1'b0, HP - 1, 1'b0, 6'd0, 28'd0);
      end
    join
    chk("hopcnt_5", hif.hop_cnt, 5);

    // One entry, three slots: underrun from slot 2, sticky in IDLE
    push_hop(6'd3, 10);
    pulse_start(1'b0);
    run_slot(1'b1, 1'b0, -1, 1'b0, 6'd0, 28'd0);
    run_slot(1'b0, 1'b1, -1, 1'b0, 6'd0, 28'd0);
    run_slot(1'b0, 1'b1, 100, 1'b0, 6'd0, 28'd0);
    chk("underrun_sticky", hif.underrun, 1);
    chk("hopcnt_3", hif.hop_cnt, 3);

    // Mid-slot stop, then resume with remaining entry
    push_hop(6'd2, 10);
    push_hop(6'd4, 10);
    pulse_start(1'b0);
    chk("start_clr_und", hif.underrun, 0);
    run_slot(1'b1, 1'b0, 700, 1'b0, 6'd0, 28'd0);
    pulse_start(1'b0);
    run_slot(1'b1, 1'b0, 20, 1'b0, 6'd0, 28'd0);

    // Table write colliding with the slot's read of entry 7
    push_hop(6'd7, 10);
    pulse_start(1'b0);
    run_slot(1'b1, 1'b0, 30, 1'b1, 6'd7, 28'h0ABCDEF);
    push_hop(6'd7, 10);
    pulse_start(1'b1);   // stop coincident with start must be ignored
    run_slot(1'b1, 1'b0, -1, 1'b0, 6'd0, 28'd0);
    run_slot(1'b0, 1'b1, 5, 1'b0, 6'd0, 28'd0);

    // Reset mid-slot with data gate open
    push_hop(6'd3, 10);
    push_hop(6'd4, 10);
    pulse_start(1'b0);
    repeat (500) @(negedge clk_200m);
    chk("pre_rst_data", hif.tx_data_en, 1);
    #1 cfg_rst = 1'b1;
    #1;
    chk("rst_data", hif.tx_data_en, 0);
    chk("rst_busy2", hif.busy, 0);
    chk("rst_dds", hif.tx_dds_en, 0);
    chk("rst_fcw2", hif.fcw_data, 0);
    chk("rst_hopcnt2", hif.hop_cnt, 0);
    chk("rst_ready2", hif.hop_ready, 0);
    sb.delete();
    @(negedge clk_200m);
    cfg_rst = 1'b0;
    @(negedge clk_200m);
    chk("rel_ready2", hif.hop_ready, 1);
    pulse_start(1'b0);
    run_slot(1'b0, 1'b1, 50, 1'b0, 6'd0, 28'd0);
    push_hop(6'd5, 10);
    pulse_start(1'b0);
    run_slot(1'b1, 1'b0, 50, 1'b0, 6'd0, 28'd0);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/duc_hop_ctrl.md
Name: duc_hop_ctrl

Overview:
- Frequency-hop scheduler for the TX digital up-converter.
- Holds a 64-entry table of 28-bit DDS frequency control words and accepts hop channel indices through a valid/ready queue.
- On a fixed hop-slot grid it looks up the FCW, loads it into the DDS with a single-cycle write strobe, and gates TX baseband data while the DDS and mixer settle.
- Sits between the link-layer hop sequencer and the DUC I/Q mixer.

Parameters:
- HOP_PERIOD, 1300: slot length in clk_200m cycles (6.5 us). Legal range is 16 to 65535.
- GUARD, 12: blanking cycles after the DDS load, covering DDS plus multiplier latency. Legal range is 1 to HOP_PERIOD-4.
- FIFO_DEPTH, 4: hop queue depth. Power of two.

Ports:
- clk_200m  in  1  system clock
- cfg_rst  in  1  asynchronous reset, active-high
- tbl_wr_en  in  1  FCW table write strobe
- tbl_wr_addr  in  6  table write address
- tbl_wr_data  in  28  FCW to store
- tx_start  in  1  one-cycle pulse; start slot grid
- tx_stop  in  1  one-cycle pulse; stop at end of current slot
- hop_valid  in  1  hop entry valid
- hop_chan  in  6  channel index of the hop entry
- hop_ready  out  1  queue can accept an entry
- fcw_data  out  28  FCW to the DDS
- tx_dds_en  out  1  DDS FCW write enable, one cycle per loaded slot
- tx_data_en  out  1  baseband data gate to the mixer
- hop_strobe  out  1  one-cycle pulse at each slot start
- busy  out  1  slot grid running
- underrun  out  1  sticky; a slot started with an empty queue
- hop_cnt  out  16  slots started since tx_start, wraps at 65535

Behaviour:

Reset:
- On cfg_rst, all outputs go to 0 asynchronously, except hop_ready, which goes to 1 once reset is released.
- Queue is flushed, state returns to IDLE, slot_cnt is cleared.
- Table contents are not reset.
- Reset mid-slot aborts the slot immediately; tx_data_en drops in the same cycle.

Table:
- Synchronous write on tbl_wr_en; writes are accepted in any state.
- Registered read with 1-cycle latency.
- A read and a write to the same address in the same cycle return the old value (read-first).

Queue:
- hop_ready = !full, computed from registered state.
- Push on hop_valid & hop_ready.
- Pop only at slot start.
- Push and pop in the same cycle is legal; occupancy is unchanged.
- When full, hop_ready is 0 and hop_valid is ignored.
- Queue contents persist across stop/start.

States:

IDLE:
- busy=0, tx_data_en=0, tx_dds_en=0.
- tx_start -> RUN with slot_cnt=0. On that transition: underrun cleared, hop_cnt=0.
- tx_stop is ignored in IDLE, including when it coincides with tx_start.

RUN:
- busy=1. slot_cnt counts 0..HOP_PERIOD-1 and wraps.
- tx_start is ignored in RUN.
- tx_stop sets stop_pending. When slot_cnt==HOP_PERIOD-1 and stop_pending: go to IDLE next cycle, clear stop_pending.
- If tx_stop arrives on the slot's last cycle itself, the stop takes effect at the end of that slot.

Per slot, at slot_cnt==0:
- hop_strobe=1, hop_cnt increments.
- If the queue is non-empty: pop, issue table read, mark the slot loaded. Otherwise: set underrun, mark the slot empty.

slot_cnt==1, loaded slot only:
- fcw_data takes the table output and is held until the next load.
- tx_dds_en=1 for exactly this cycle.

tx_data_en:
- Registered.
- High for slot_cnt in [GUARD+2, HOP_PERIOD-1] of loaded slots only.
- Low during the whole of empty slots and in IDLE.
- The first loaded slot after tx_start gates identically; there is no special case.

Latency:
- tx_start pulse to first hop_strobe: 1 cycle.
- hop_strobe to tx_dds_en: 1 cycle.
- tx_dds_en to tx_data_en rising: GUARD+1 cycles.

Test Plan:
1. Write table[5]=0x1234567, push chan 5, pulse tx_start -> hop_strobe one cycle later; next cycle fcw_data=0x1234567 and tx_dds_en=1 for 1 cycle; tx_data_en high from slot_cnt 14 through 1299 (GUARD=12).
2. Push chans 1,2,3,4,5 back-to-back while IDLE -> hop_ready drops after the 4th accept; the 5th is held until the first pop; 5 consecutive slots each load the correct FCW and hop_cnt reaches 5.
3. Run with 1 queued entry for 3 slots -> slot 1 loaded; slots 2 and 3 have tx_data_en=0 and no tx_dds_en; underrun=1 from slot 2 and stays set until the next tx_start.
4. tx_stop at slot_cnt=700 -> tx_data_en and busy stay high until slot_cnt=1299, then both are 0; a later tx_start resumes with the remaining queue entries.
5. Write table[7] in the same cycle a slot reads entry 7 -> old FCW is loaded; the next slot using chan 7 loads the new FCW.
6. Assert cfg_rst at slot_cnt=500 with tx_data_en high -> all outputs 0 immediately, queue empty, hop_ready=1 after release, table contents retained.
